// File: rtl/chess_turn_scheduler.sv
// Two-player chess clock and turn arbiter: per-side countdown, move accept/reject, pause, timeout.
// Optional build macro TURN_INCREMENT_EN adds INC_SECONDS (saturating) to the mover on each accepted move.
module chess_turn_scheduler #(
  parameter int INIT_SECONDS = 300,
  parameter int TIME_WIDTH   = 10,
  parameter int INC_SECONDS  = 5
) (
  input  logic                  clock,
  input  logic                  resetApp,
  input  logic                  SecTick,
  input  logic                  StartGame,
  input  logic                  PauseToggle,
  input  logic                  MoveReq,
  input  logic                  MoveSide,
  output logic                  Player,
  output logic                  MoveAck,
  output logic                  MoveNack,
  output logic [TIME_WIDTH-1:0] WhiteTime,
  output logic [TIME_WIDTH-1:0] BlackTime,
  output logic [7:0]            MoveCount,
  output logic                  GameOver,
  output logic                  Winner,
  output logic                  Running
);

  typedef enum logic [2:0] {
    IDLE,
    WHITE_TURN,
    BLACK_TURN,
    PAUSED,
    GAME_OVER
  } state_t;

`ifdef TURN_INCREMENT_EN
  localparam bit INC_EN = 1'b1;
`else
  localparam bit INC_EN = 1'b0;
`endif

  localparam logic [31:0] INC_ADD  = INC_EN ? 32'(INC_SECONDS) : 32'd0;
  localparam logic [31:0] TIME_MAX = (32'd1 << TIME_WIDTH) - 32'd1;

  state_t                state;
  logic [TIME_WIDTH-1:0] mover_time;
  logic [TIME_WIDTH-1:0] charged_time;
  logic [TIME_WIDTH-1:0] credited_time;
  logic [31:0]           credit_sum;
  logic                  move_valid;

  // The tick is always charged before anything else is decided this cycle.
  always_comb begin
    mover_time   = Player ? WhiteTime : BlackTime;
    charged_time = mover_time;
    if (SecTick && (mover_time != '0)) begin
      charged_time = mover_time - TIME_WIDTH'(1);
    end
    credit_sum    = 32'(charged_time) + INC_ADD;
    credited_time = (credit_sum > TIME_MAX) ? TIME_MAX[TIME_WIDTH-1:0]
                                            : credit_sum[TIME_WIDTH-1:0];
    move_valid    = MoveReq && (MoveSide == Player);
  end

  always_ff @(posedge clock) begin
    if (resetApp) begin
      state     <= IDLE;
      Player    <= 1'b1;
      WhiteTime <= TIME_WIDTH'(INIT_SECONDS);
      BlackTime <= TIME_WIDTH'(INIT_SECONDS);
      MoveCount <= 8'd0;
      MoveAck   <= 1'b0;
      MoveNack  <= 1'b0;
      GameOver  <= 1'b0;
      Winner    <= 1'b0;
      Running   <= 1'b0;
    end else begin
      MoveAck  <= 1'b0;
      MoveNack <= 1'b0;
      case (state)
        IDLE: begin
          MoveNack <= MoveReq;
          if (StartGame) begin
            state   <= WHITE_TURN;
            Running <= 1'b1;
          end
        end
        WHITE_TURN, BLACK_TURN: begin
          if (Player) WhiteTime <= charged_time;
          else        BlackTime <= charged_time;
          // Timeout outranks pause and move requests in the same cycle.
          if (charged_time == '0) begin
            state    <= GAME_OVER;
            GameOver <= 1'b1;
            Winner   <= ~Player;
            Running  <= 1'b0;
            MoveNack <= MoveReq;
          end else if (PauseToggle) begin
            state    <= PAUSED;
            Running  <= 1'b0;
            MoveNack <= MoveReq;
          end else if (move_valid) begin
            MoveAck   <= 1'b1;
            Player    <= ~Player;
            MoveCount <= MoveCount + 8'd1;
            state     <= Player ? BLACK_TURN : WHITE_TURN;
            if (Player) WhiteTime <= credited_time;
            else        BlackTime <= credited_time;
          end else begin
            MoveNack <= MoveReq;
          end
        end
        PAUSED: begin
          // Player still holds the side to move, so it doubles as the remembered turn.
          MoveNack <= MoveReq;
          if (PauseToggle) begin
            state   <= Player ? WHITE_TURN : BLACK_TURN;
            Running <= 1'b1;
          end
        end
        GAME_OVER: begin
          MoveNack <= MoveReq;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chess_turn_scheduler.sv
// Self-checking bench for chess_turn_scheduler: directed scenarios plus randomized play against a rule model.
module tb_chess_turn_scheduler;

  localparam int TW   = 10;
  localparam int INIT = 300;
  localparam int INC  = 5;
  localparam int MAXT = 1023;
`ifdef TURN_INCREMENT_EN
  localparam int M_INC = INC;
`else
  localparam int M_INC = 0;
`endif

  logic          clock = 1'b0;
  logic          resetApp = 1'b1;
  logic          SecTick = 1'b0, StartGame = 1'b0, PauseToggle = 1'b0, MoveReq = 1'b0, MoveSide = 1'b0;
  logic          Player, MoveAck, MoveNack, GameOver, Winner, Running;
  logic [TW-1:0] WhiteTime, BlackTime;
  logic [7:0]    MoveCount;
  logic          s_Player, s_MoveAck, s_MoveNack, s_GameOver, s_Winner, s_Running;
  logic [TW-1:0] s_WhiteTime, s_BlackTime;
  logic [7:0]    s_MoveCount;

  chess_turn_scheduler #(.INIT_SECONDS(INIT), .TIME_WIDTH(TW), .INC_SECONDS(INC)) dut (
    .clock(clock), .resetApp(resetApp), .SecTick(SecTick), .StartGame(StartGame),
    .PauseToggle(PauseToggle), .MoveReq(MoveReq), .MoveSide(MoveSide),
    .Player(Player), .MoveAck(MoveAck), .MoveNack(MoveNack),
    .WhiteTime(WhiteTime), .BlackTime(BlackTime), .MoveCount(MoveCount),
    .GameOver(GameOver), .Winner(Winner), .Running(Running)
  );

  // Second instance starts near the top of the timer range to exercise saturation.
  chess_turn_scheduler #(.INIT_SECONDS(1020), .TIME_WIDTH(TW), .INC_SECONDS(INC)) dut_sat (
    .clock(clock), .resetApp(resetApp), .SecTick(SecTick), .StartGame(StartGame),
    .PauseToggle(PauseToggle), .MoveReq(MoveReq), .MoveSide(MoveSide),
    .Player(s_Player), .MoveAck(s_MoveAck), .MoveNack(s_MoveNack),
    .WhiteTime(s_WhiteTime), .BlackTime(s_BlackTime), .MoveCount(s_MoveCount),
    .GameOver(s_GameOver), .Winner(s_Winner), .Running(s_Running)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  bit m_started, m_paused, m_over, m_player, m_winner, m_ack, m_nack;
  int m_time [2];
  int m_count;

  task automatic model_reset();
    m_started = 0; m_paused = 0; m_over = 0; m_player = 1; m_winner = 0;
    m_ack = 0; m_nack = 0; m_time[0] = INIT; m_time[1] = INIT; m_count = 0;
  endtask

  task automatic model_edge(input bit tick, input bit start, input bit pause, input bit req, input bit side);
    int t;
    m_ack = 0;
    m_nack = 0;
    if (!m_started) begin
      m_nack = req;
      if (start) m_started = 1;
    end else if (m_over) begin
      m_nack = req;
    end else if (m_paused) begin
      m_nack = req;
      if (pause) m_paused = 0;
    end else begin
      t = m_time[m_player];
      if (tick && t > 0) t = t - 1;
      m_time[m_player] = t;
      if (t == 0) begin
        m_over = 1; m_winner = !m_player; m_nack = req;
      end else if (pause) begin
        m_paused = 1; m_nack = req;
      end else if (req && side == m_player) begin
        m_ack = 1;
        m_time[m_player] = (t + M_INC > MAXT) ? MAXT : t + M_INC;
        m_player = !m_player;
        m_count = (m_count + 1) % 256;
      end else begin
        m_nack = req;
      end
    end
  endtask

  function automatic logic [33:0] model_obs();
    return {m_player, m_ack, m_nack, TW'(m_time[1]), TW'(m_time[0]), 8'(m_count),
            m_over, m_winner, m_started && !m_paused && !m_over};
  endfunction

  function automatic logic [33:0] dut_obs();
    return {Player, MoveAck, MoveNack, WhiteTime, BlackTime, MoveCount, GameOver, Winner, Running};
  endfunction

  task automatic cyc(input bit tick, input bit start, input bit pause, input bit req, input bit side);
    SecTick = tick; StartGame = start; PauseToggle = pause; MoveReq = req; MoveSide = side;
    @(posedge clock);
    model_edge(tick, start, pause, req, side);
    #1;
    SecTick = 0; StartGame = 0; PauseToggle = 0; MoveReq = 0; MoveSide = 0;
  endtask

  task automatic do_reset();
    resetApp = 1;
    SecTick = 1'($urandom); StartGame = 1'($urandom); PauseToggle = 1'($urandom);
    MoveReq = 1'($urandom); MoveSide = 1'($urandom);
    @(posedge clock);
    #1;
    resetApp = 0;
    SecTick = 0; StartGame = 0; PauseToggle = 0; MoveReq = 0; MoveSide = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (Player !== 1'b1) begin failures++; $display("FAIL reset_player got=%0b exp=1", Player); end
    checks++; if (WhiteTime !== TW'(INIT) || BlackTime !== TW'(INIT)) begin
      failures++; $display("FAIL reset_times got=%0d/%0d exp=%0d/%0d", WhiteTime, BlackTime, INIT, INIT); end
    checks++; if ({MoveCount, MoveAck, MoveNack, GameOver, Winner, Running} !== 13'd0) begin
      failures++; $display("FAIL reset_flags got cnt=%0d ack=%0b nack=%0b go=%0b win=%0b run=%0b exp all 0",
                           MoveCount, MoveAck, MoveNack, GameOver, Winner, Running); end
    cyc(1, 0, 1, 1, 1);
    checks++; if (MoveNack !== 1'b1 || WhiteTime !== TW'(INIT) || Running !== 1'b0) begin
      failures++; $display("FAIL idle_ignore got nack=%0b wt=%0d run=%0b exp 1/%0d/0", MoveNack, WhiteTime, Running, INIT); end
  endtask

  task automatic test_start_ticks();
    do_reset();
    cyc(0, 1, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0);
    checks++; if (WhiteTime !== 10'd297 || BlackTime !== 10'd300 || Player !== 1'b1 || Running !== 1'b1) begin
      failures++; $display("FAIL start_ticks got wt=%0d bt=%0d pl=%0b run=%0b exp 297/300/1/1",
                           WhiteTime, BlackTime, Player, Running); end
  endtask

  task automatic test_move();
    cyc(0, 0, 0, 1, 1);
    checks++; if (MoveAck !== 1'b1 || MoveNack !== 1'b0 || Player !== 1'b0 || MoveCount !== 8'd1) begin
      failures++; $display("FAIL move_accept got ack=%0b nack=%0b pl=%0b cnt=%0d exp 1/0/0/1",
                           MoveAck, MoveNack, Player, MoveCount); end
    cyc(0, 1, 0, 0, 0);
    checks++; if (MoveAck !== 1'b0 || MoveCount !== 8'd1 || Running !== 1'b1) begin
      failures++; $display("FAIL ack_width got ack=%0b cnt=%0d run=%0b exp 0/1/1", MoveAck, MoveCount, Running); end
    cyc(0, 0, 0, 1, 1);
    checks++; if (MoveNack !== 1'b1 || MoveAck !== 1'b0 || Player !== 1'b0 || MoveCount !== 8'd1) begin
      failures++; $display("FAIL wrong_side got nack=%0b ack=%0b pl=%0b cnt=%0d exp 1/0/0/1",
                           MoveNack, MoveAck, Player, MoveCount); end
    cyc(1, 0, 0, 0, 0);
    checks++; if (WhiteTime !== 10'd297 || BlackTime !== 10'd299) begin
      failures++; $display("FAIL black_tick got wt=%0d bt=%0d exp 297/299", WhiteTime, BlackTime); end
  endtask

  task automatic test_pause();
    cyc(0, 0, 1, 0, 0);
    checks++; if (Running !== 1'b0 || GameOver !== 1'b0) begin
      failures++; $display("FAIL pause_enter got run=%0b go=%0b exp 0/0", Running, GameOver); end
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, (i == 2), 0);
    checks++; if (MoveNack !== 1'b0 || WhiteTime !== 10'd297 || BlackTime !== 10'd299) begin
      failures++; $display("FAIL pause_frozen got nack=%0b wt=%0d bt=%0d exp 0/297/299", MoveNack, WhiteTime, BlackTime); end
    cyc(0, 0, 0, 1, 0);
    checks++; if (MoveNack !== 1'b1 || MoveCount !== 8'd1) begin
      failures++; $display("FAIL pause_move got nack=%0b cnt=%0d exp 1/1", MoveNack, MoveCount); end
    cyc(0, 0, 1, 0, 0);
    checks++; if (Running !== 1'b1 || Player !== 1'b0 || BlackTime !== 10'd299) begin
      failures++; $display("FAIL pause_resume got run=%0b pl=%0b bt=%0d exp 1/0/299", Running, Player, BlackTime); end
    cyc(0, 0, 1, 1, 0);
    checks++; if (MoveNack !== 1'b1 || MoveAck !== 1'b0 || Running !== 1'b0 || Player !== 1'b0) begin
      failures++; $display("FAIL pause_beats_move got nack=%0b ack=%0b run=%0b pl=%0b exp 1/0/0/0",
                           MoveNack, MoveAck, Running, Player); end
    cyc(0, 0, 1, 0, 0);
  endtask

  task automatic test_timeout();
    do_reset();
    cyc(0, 1, 0, 0, 0);
    repeat (INIT - 1) cyc(1, 0, 0, 0, 0);
    checks++; if (WhiteTime !== 10'd1 || GameOver !== 1'b0) begin
      failures++; $display("FAIL pre_timeout got wt=%0d go=%0b exp 1/0", WhiteTime, GameOver); end
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    checks++; if (GameOver !== 1'b1 || Winner !== 1'b0 || Running !== 1'b0 || WhiteTime !== 10'd0) begin
      failures++; $display("FAIL timeout got go=%0b win=%0b run=%0b wt=%0d exp 1/0/0/0", GameOver, Winner, Running, WhiteTime); end
    cyc(1, 1, 1, 1, 1);
    checks++; if (MoveNack !== 1'b1 || GameOver !== 1'b1 || WhiteTime !== 10'd0 || MoveCount !== 8'd0) begin
      failures++; $display("FAIL over_sticky got nack=%0b go=%0b wt=%0d cnt=%0d exp 1/1/0/0", MoveNack, GameOver, WhiteTime, MoveCount); end
    do_reset();
    checks++; if (GameOver !== 1'b0 || Running !== 1'b0 || WhiteTime !== TW'(INIT)) begin
      failures++; $display("FAIL over_reset got go=%0b run=%0b wt=%0d exp 0/0/%0d", GameOver, Running, WhiteTime, INIT); end
  endtask

  task automatic test_tick_move_collision();
    do_reset();
    cyc(0, 1, 0, 0, 0);
    repeat (INIT - 1) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1);
    checks++; if (MoveNack !== 1'b1 || MoveAck !== 1'b0 || GameOver !== 1'b1 || Winner !== 1'b0 || MoveCount !== 8'd0) begin
      failures++; $display("FAIL collision got nack=%0b ack=%0b go=%0b win=%0b cnt=%0d exp 1/0/1/0/0",
                           MoveNack, MoveAck, GameOver, Winner, MoveCount); end
  endtask

  task automatic test_saturation();
    int exp_wt;
    exp_wt = (M_INC != 0) ? MAXT : 1020;
    do_reset();
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1);
    checks++; if (s_MoveAck !== 1'b1 || s_WhiteTime !== TW'(exp_wt) || s_Player !== 1'b0) begin
      failures++; $display("FAIL saturation got ack=%0b wt=%0d pl=%0b exp 1/%0d/0", s_MoveAck, s_WhiteTime, s_Player, exp_wt); end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(599) == 0) do_reset();
      else cyc($urandom_range(99) < 20, $urandom_range(99) < 5, $urandom_range(99) < 4,
               $urandom_range(99) < 35, 1'($urandom));
      checks++;
      if (dut_obs() !== model_obs()) begin
        failures++;
        if (errs < 10) $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_obs(), model_obs());
        errs++;
      end
      if (MoveAck && MoveNack) begin
        failures++;
        $display("FAIL ack_nack_overlap cyc=%0d got both=1 exp exclusive", i);
      end
    end
  endtask

  initial begin
    model_reset();
    @(posedge clock);
    #1;
    test_reset();
    test_start_ticks();
    test_move();
    test_pause();
    test_timeout();
    test_tick_move_collision();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chess_turn_scheduler.md
CHESS_TURN_SCHEDULER -- requirements
Module: chess_turn_scheduler

Interface
REQ-001 SHALL have parameter INIT_SECONDS, default 300, the starting time per player in seconds.
REQ-002 SHALL have parameter TIME_WIDTH, default 10, the width of each player timer.
REQ-003 SHALL have parameter INC_SECONDS, default 5, the per-move increment used only under TURN_INCREMENT_EN.
REQ-004 SHALL have port clock  input  1  system clock; one clock domain, all logic on its rising edge.
REQ-005 SHALL have port resetApp  input  1  synchronous, active-high reset.
REQ-006 SHALL have port SecTick  input  1  one-cycle enable pulse, once per second.
REQ-007 SHALL have port StartGame  input  1  pulse that starts a game from IDLE.
REQ-008 SHALL have port PauseToggle  input  1  pulse that toggles between running and PAUSED.
REQ-009 SHALL have port MoveReq  input  1  one-cycle pulse from the layout datapath reporting a committed move.
REQ-010 SHALL have port MoveSide  input  1  side that made the move: 1 = white, 0 = black; sampled with MoveReq.
REQ-011 SHALL have port Player  output  1  side to move: 1 = white, 0 = black.
REQ-012 SHALL have port MoveAck / MoveNack  output  1 each  one-cycle pulses that accept or reject a MoveReq.
REQ-013 SHALL have port WhiteTime, BlackTime  output  TIME_WIDTH each  remaining seconds per player.
REQ-014 SHALL have port MoveCount  output  8  number of accepted moves; wraps from 255 to 0.
REQ-015 SHALL have port GameOver  output  1  high while in GAME_OVER.
REQ-016 SHALL have port Winner  output  1  winning side; valid only while GameOver = 1.
REQ-017 SHALL have port Running  output  1  high in WHITE_TURN or BLACK_TURN.

Function
REQ-018 SHALL implement the FSM states IDLE, WHITE_TURN, BLACK_TURN, PAUSED and GAME_OVER.
REQ-019 IDLE SHALL go to WHITE_TURN on StartGame; all other inputs SHALL be ignored in IDLE.
REQ-020 In a TURN state, SecTick SHALL decrement only the side-to-move timer, by 1, in the same cycle.
REQ-021 A timer reaching 0 SHALL move the FSM to GAME_OVER on the next edge, with Winner = opponent; timers SHALL never underflow.
REQ-022 A MoveReq whose MoveSide equals Player in a TURN state SHALL produce MoveAck on the next cycle.
REQ-023 An accepted move SHALL toggle Player, switch the TURN state and increment MoveCount, all on that same edge.
REQ-024 A MoveReq with the wrong side, or any MoveReq in IDLE, PAUSED or GAME_OVER, SHALL produce MoveNack on the next cycle and change no state.
REQ-025 If SecTick and a valid MoveReq arrive in the same cycle, the tick SHALL first be charged to the mover; if that tick takes the mover's timer to 0, the result SHALL be timeout (MoveNack, GAME_OVER), otherwise the move SHALL be accepted.
REQ-026 PauseToggle in a TURN state SHALL enter PAUSED and remember the turn; in PAUSED it SHALL return to the remembered turn.
REQ-027 Timers SHALL be frozen in PAUSED.
REQ-028 PauseToggle SHALL take precedence over MoveReq in the same cycle; that MoveReq SHALL then receive MoveNack.
REQ-029 GAME_OVER SHALL be left only by reset.
REQ-030 StartGame outside IDLE SHALL be ignored.
REQ-031 MoveAck and MoveNack SHALL never assert together, and each SHALL be exactly one cycle wide.

Reset
REQ-032 When resetApp = 1 at a clock edge, the FSM SHALL enter IDLE regardless of its current state, including mid-game or PAUSED.
REQ-033 That reset SHALL also set Player = 1, WhiteTime = BlackTime = INIT_SECONDS, MoveCount = 0, MoveAck = MoveNack = 0, GameOver = 0, Winner = 0 and Running = 0.
REQ-034 Inputs SHALL be ignored during the reset cycle.

Configuration
REQ-035 Macro TURN_INCREMENT_EN, when defined, SHALL add INC_SECONDS to the mover's timer on each accepted move, applied after any same-cycle tick.
REQ-036 That increment SHALL saturate at 2^TIME_WIDTH-1.
REQ-037 Without TURN_INCREMENT_EN, the timers SHALL only ever decrement, and INC_SECONDS SHALL be unused.

Verification
REQ-038 Reset, then StartGame, then 3 SecTicks -> WHITE_TURN, WhiteTime = 297, BlackTime = 300, Player = 1.
REQ-039 In WHITE_TURN, MoveReq with MoveSide = 1 -> MoveAck 1 cycle later, Player = 0, MoveCount = 1; a following MoveReq with MoveSide = 1 -> MoveNack, no state change.
REQ-040 With INIT_SECONDS = 2, 2 SecTicks in WHITE_TURN -> GameOver = 1, Winner = 0; a later MoveReq -> MoveNack; only resetApp exits.
REQ-041 PauseToggle, 5 SecTicks, PauseToggle -> timers unchanged, original turn resumed; a MoveReq issued while paused -> MoveNack.
REQ-042 WhiteTime = 1 with SecTick and MoveReq(side 1) in the same cycle -> MoveNack, GameOver = 1, Winner = 0.
REQ-043 With TURN_INCREMENT_EN, WhiteTime = 1020 and an accepted white move -> WhiteTime = 1023 (saturated); without the macro -> WhiteTime = 1020.
